// File: rtl/olivia_multicycle_ctrl.sv
// olivia_multicycle_ctrl
//   Multi-cycle sequencer for the Olivia LEGv8 datapath. Steps each instruction
//   through FETCH/DECODE/EXEC/MEM/WB, drives per-state datapath strobes, waits on
//   a variable-latency data-RAM handshake and keeps cycle/retire counters.
// Ports
//   clk, rst (async active-low)
//   run        - allows leaving FETCH
//   opcode     - instruction[31:21], decoded in DECODE
//   zero_flag  - ALU zero, selects CBZ branch in EXEC
//   mem_ready  - data RAM access done (MEM only)
//   ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op, mem_read, mem_write,
//   mem2reg, reg_write - datapath strobes
//   state, halted, illegal_op, mem_fault - status
//   cycle_cnt, instret_cnt - free-running counters (frozen in HALT)
module olivia_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [10:0]      opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem2reg,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_LD, C_ST, C_CBZ, C_B
  } cls_t;

  function automatic cls_t decode_op(input logic [10:0] op);
    cls_t c;
    c = C_NONE;
    case (op)
      11'h458, 11'h658, 11'h450, 11'h550: c = C_R;
      11'h7C2:                            c = C_LD;
      11'h7C0:                            c = C_ST;
      default: begin
        if (op[10:3] == 8'hB4)      c = C_CBZ;  // 0x5A0..0x5A7
        else if (op[10:5] == 6'h05) c = C_B;    // 0x0A0..0x0BF
      end
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  cls_t               cls_q, dec_cls;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               illegal_q, fault_q;
  logic               mem_to;

  assign dec_cls = decode_op(opcode);
  // The last permitted MEM cycle: counter has seen MEM_TIMEOUT-1 misses already.
  assign mem_to  = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // state register and bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      cls_q       <= C_NONE;
      wait_cnt    <= '0;
      illegal_q   <= 1'b0;
      fault_q     <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
      // Held at zero outside MEM so every MEM visit starts a fresh wait window.
      if (state_q != S_MEM)  wait_cnt <= '0;
      else if (!mem_ready)   wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state_q == S_DECODE && dec_cls == C_NONE)      illegal_q <= 1'b1;
      if (state_q == S_MEM && !mem_ready && mem_to)      fault_q   <= 1'b1;
      if (state_q != S_HALT) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (pc_write)          instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (run) state_d = S_DECODE;
      S_DECODE: state_d = (dec_cls == C_NONE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_R:        state_d = S_WB;
          C_LD, C_ST: state_d = S_MEM;
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // a ready on the timeout cycle still completes the access
        if (mem_ready)   state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
        else if (mem_to) state_d = S_HALT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // outputs
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg2loc   = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem2reg   = 1'b0;
    reg_write = 1'b0;
    case (state_q)
      S_FETCH: ir_write = run;
      S_EXEC: begin
        case (cls_q)
          C_R:  alu_op = 2'b10;
          C_LD: alu_src = 1'b1;
          C_ST: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
          end
          C_CBZ: begin
            alu_op   = 2'b01;
            reg2loc  = 1'b1;
            pc_write = 1'b1;
            pc_src   = zero_flag;
          end
          C_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        alu_src = 1'b1;
        if (cls_q == C_LD) mem_read = 1'b1;
        if (cls_q == C_ST) begin
          mem_write = 1'b1;
          reg2loc   = 1'b1;
          pc_write  = mem_ready;  // store retires in its completing cycle
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = (cls_q == C_LD);
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign illegal_op = illegal_q;
  assign mem_fault  = fault_q;

endmodule

// File: tb/tb_olivia_multicycle_ctrl.sv
// Randomized bench for olivia_multicycle_ctrl. Each instruction is expanded into
// its expected per-cycle (state, strobes) sequence from the ISA-level rules; the
// counters and sticky flags are tracked as plain integers.
module tb_olivia_multicycle_ctrl;
  localparam int TO = 15;

  // strobe bit positions in the packed compare vector
  localparam logic [10:0] IRW = 11'h400, PCW = 11'h200, PCS = 11'h100, R2L = 11'h080,
                          ASRC = 11'h040, AOP_R = 11'h020, AOP_PB = 11'h010,
                          MRD = 11'h008, MWR = 11'h004, M2R = 11'h002, RW = 11'h001;

  logic        clk = 1'b0, rst = 1'b0, run = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0;
  logic [10:0] opcode = '0;
  logic        ir_write, pc_write, pc_src, reg2loc, alu_src, mem_read, mem_write;
  logic        mem2reg, reg_write, halted, illegal_op, mem_fault;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  olivia_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem2reg(mem2reg), .reg_write(reg_write), .state(state),
    .halted(halted), .illegal_op(illegal_op), .mem_fault(mem_fault),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  wire [10:0] strb = {ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
                      mem_read, mem_write, mem2reg, reg_write};

  int errs = 0, checks = 0;
  int m_cyc = 0, m_ret = 0;
  bit m_ill = 0, m_flt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] nz();
    return 11'($urandom);
  endfunction

  // 0 illegal, 1 R, 2 LD, 3 ST, 4 CBZ, 5 B
  function automatic int op_class(input logic [10:0] op);
    int v;
    v = int'(op);
    if (v == 'h458 || v == 'h658 || v == 'h450 || v == 'h550) return 1;
    if (v == 'h7C2) return 2;
    if (v == 'h7C0) return 3;
    if (v >= 'h5A0 && v <= 'h5A7) return 4;
    if (v >= 'h0A0 && v <= 'h0BF) return 5;
    return 0;
  endfunction

  // One clock: apply inputs, check at negedge, then advance the model past the edge.
  task automatic cyc(input logic [2:0] es, input logic [10:0] estb, input logic r,
                     input logic [10:0] op, input logic zf, input logic rdy);
    run = r; opcode = op; zero_flag = zf; mem_ready = rdy;
    @(negedge clk);
    chk("state", 32'(state), 32'(es));
    chk("strobes", 32'(strb), 32'(estb));
    chk("halted", 32'(halted), 32'(es == 3'd5));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
    chk("mem_fault", 32'(mem_fault), 32'(m_flt));
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instret_cnt", instret_cnt, m_ret);
    @(posedge clk); #1;
    if (es != 3'd5) m_cyc++;
    if (estb[9]) m_ret++;
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0;
    m_cyc = 0; m_ret = 0; m_ill = 0; m_flt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'(strb), 0);
    chk("rst_flags", 32'({halted, illegal_op, mem_fault}), 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instret_cnt", instret_cnt, 0);
    rst = 1'b1;
  endtask

  // w = MEM cycles without ready before the ready cycle (w>=TO means never ready)
  task automatic run_instr(input logic [10:0] op, input logic zf, input int w, input int stall);
    int c;
    logic [10:0] base;
    c = op_class(op);
    for (int i = 0; i < stall; i++) cyc(3'd0, '0, 1'b0, nz(), rb(), rb());
    cyc(3'd0, IRW, 1'b1, nz(), rb(), rb());
    cyc(3'd1, '0, rb(), op, rb(), rb());
    if (c == 0) begin
      m_ill = 1;
      return;
    end
    case (c)
      1: cyc(3'd2, AOP_R, rb(), nz(), zf, rb());
      2: cyc(3'd2, ASRC, rb(), nz(), zf, rb());
      3: cyc(3'd2, ASRC | R2L, rb(), nz(), zf, rb());
      4: cyc(3'd2, AOP_PB | R2L | PCW | (zf ? PCS : 11'h0), rb(), nz(), zf, rb());
      default: cyc(3'd2, PCW | PCS, rb(), nz(), zf, rb());
    endcase
    if (c == 2 || c == 3) begin
      base = (c == 2) ? (ASRC | MRD) : (ASRC | MWR | R2L);
      for (int i = 0; i < TO; i++) begin
        if (i == w) begin
          cyc(3'd3, base | ((c == 3) ? PCW : 11'h0), rb(), nz(), rb(), 1'b1);
          break;
        end
        cyc(3'd3, base, rb(), nz(), rb(), 1'b0);
        if (i == TO - 1) begin
          m_flt = 1;
          return;
        end
      end
    end
    if (c == 1 || c == 2) cyc(3'd4, RW | PCW | ((c == 2) ? M2R : 11'h0), rb(), nz(), rb(), rb());
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) cyc(3'd5, '0, rb(), nz(), rb(), rb());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rops [4];
    logic [10:0] op;
    int k;
    rops[0] = 11'h458; rops[1] = 11'h658; rops[2] = 11'h450; rops[3] = 11'h550;

    do_reset();
    run_instr(11'h458, 1'b0, 0, 3);   // stalls then ADD
    run_instr(11'h7C2, 1'b0, 2, 0);   // LD, ready on 3rd MEM cycle
    run_instr(11'h5A3, 1'b1, 0, 0);   // CBZ taken
    run_instr(11'h5A3, 1'b0, 0, 0);   // CBZ not taken
    run_instr(11'h7C0, 1'b0, 0, 1);   // ST immediate ready
    run_instr(11'h0A0, 1'b0, 0, 0);   // B low edge
    run_instr(11'h0BF, 1'b1, 0, 0);   // B high edge

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(1, 5);
      case (k)
        1: op = rops[$urandom_range(0, 3)];
        2: op = 11'h7C2;
        3: op = 11'h7C0;
        4: op = 11'h5A0 + 11'($urandom_range(0, 7));
        default: op = 11'h0A0 + 11'($urandom_range(0, 31));
      endcase
      run_instr(op, rb(), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    // store times out, then store with ready on the final permitted cycle
    run_instr(11'h7C0, 1'b0, TO, 0);
    halt_hold(4);
    do_reset();
    run_instr(11'h7C0, 1'b0, TO - 1, 0);
    run_instr(11'h458, 1'b0, 0, 0);
    // load timeout
    run_instr(11'h7C2, 1'b0, TO + 3, 0);
    halt_hold(3);
    do_reset();

    // illegal opcodes, including neighbours of legal ones
    run_instr(11'h000, 1'b0, 0, 0);
    halt_hold(3);
    do_reset();
    run_instr(11'h5A8, 1'b0, 0, 1);
    halt_hold(2);
    do_reset();
    run_instr(11'h0C0, 1'b0, 0, 0);
    halt_hold(2);
    do_reset();

    // asynchronous reset in the middle of a load's MEM wait
    run_instr(11'h650 ^ 11'h008, 1'b0, 0, 0); // 0x658 SUB
    cyc(3'd0, IRW, 1'b1, nz(), 1'b0, 1'b0);
    cyc(3'd1, '0, 1'b0, 11'h7C2, 1'b0, 1'b0);
    cyc(3'd2, ASRC, 1'b0, nz(), 1'b0, 1'b0);
    cyc(3'd3, ASRC | MRD, 1'b0, nz(), 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("midmem_mem_read_before", 32'(mem_read), 1);
    rst = 1'b0;
    #1;
    chk("midmem_mem_read_async", 32'(mem_read), 0);
    chk("midmem_state", 32'(state), 0);
    chk("midmem_cycle_cnt", cycle_cnt, 0);
    chk("midmem_instret_cnt", instret_cnt, 0);
    do_reset();
    run_instr(11'h7C2, 1'b0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
